// File: rtl/udma_eth_rx_frame_filter.sv
// rtl/udma_eth_rx_frame_filter.sv - Ethernet RX destination/runt/length filter between MAC and uDMA RX buffer
// Optional drop statistics counter: define ETH_RX_FILTER_STATS_EN.
module udma_eth_rx_frame_filter #(
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        eth_clk_i,
    input  logic        eth_rst_i,
    input  logic [47:0] cfg_mac_addr_i,
    input  logic        cfg_promisc_i,
    input  logic        cfg_bcast_en_i,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    input  logic        s_axis_tlast_i,
    input  logic        s_axis_tuser_i,
    output logic        s_axis_tready_o,
    output logic [7:0]  m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    output logic        m_axis_tlast_o,
    input  logic        m_axis_tready_i,
    output logic        drop_event_o,
    output logic        trunc_event_o,
    output logic        err_event_o,
    output logic [15:0] stat_drop_cnt_o
);

    typedef enum logic [1:0] {HDR, FLUSH, PASS, DROP} state_t;

    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);

    state_t      state;
    state_t      state_next;
    logic [47:0] hdr;
    logic [2:0]  hdr_cnt;
    logic [2:0]  rd_idx;
    logic [10:0] byte_cnt;
    logic [47:0] dst_next;
    logic [10:0] byte_cnt_inc;
    logic        addr_match;
    logic        at_max;
    logic        in_beat;
    logic [7:0]  flush_byte;
    logic        drop_set;
    logic        trunc_set;
    logic        err_set;

    // The 6th header byte is still on the bus, so the match uses it directly.
    assign dst_next     = {hdr[39:0], s_axis_tdata_i};
    assign addr_match   = cfg_promisc_i
                        | (dst_next == cfg_mac_addr_i)
                        | (cfg_bcast_en_i & (&dst_next));
    assign byte_cnt_inc = byte_cnt + 11'd1;
    assign at_max       = (byte_cnt_inc == MAX_LEN);
    assign in_beat      = s_axis_tvalid_i & s_axis_tready_o;

    always_comb begin
        flush_byte = 8'h00;
        case (rd_idx)
            3'd0:    flush_byte = hdr[47:40];
            3'd1:    flush_byte = hdr[39:32];
            3'd2:    flush_byte = hdr[31:24];
            3'd3:    flush_byte = hdr[23:16];
            3'd4:    flush_byte = hdr[15:8];
            3'd5:    flush_byte = hdr[7:0];
            default: flush_byte = 8'h00;
        endcase
    end

    always_ff @(posedge eth_clk_i or posedge eth_rst_i) begin
        if (eth_rst_i) begin
            state <= HDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        s_axis_tready_o = 1'b0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = 8'h00;
        m_axis_tlast_o  = 1'b0;
        drop_set        = 1'b0;
        trunc_set       = 1'b0;
        err_set         = 1'b0;
        case (state)
            HDR: begin
                s_axis_tready_o = 1'b1;
                if (s_axis_tvalid_i) begin
                    if (s_axis_tlast_i) begin
                        drop_set = 1'b1;
                    end else if (hdr_cnt == 3'd5) begin
                        if (addr_match) begin
                            state_next = FLUSH;
                        end else begin
                            state_next = DROP;
                            drop_set   = 1'b1;
                        end
                    end
                end
            end
            FLUSH: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = flush_byte;
                if (m_axis_tready_i && rd_idx == 3'd5) begin
                    state_next = PASS;
                end
            end
            PASS: begin
                m_axis_tvalid_o = s_axis_tvalid_i;
                s_axis_tready_o = m_axis_tready_i;
                m_axis_tdata_o  = s_axis_tdata_i;
                m_axis_tlast_o  = s_axis_tlast_i | at_max;
                if (in_beat) begin
                    if (s_axis_tlast_i) begin
                        state_next = HDR;
                        err_set    = s_axis_tuser_i;
                    end else if (at_max) begin
                        state_next = DROP;
                        trunc_set  = 1'b1;
                    end
                end
            end
            DROP: begin
                s_axis_tready_o = 1'b1;
                if (s_axis_tvalid_i && s_axis_tlast_i) begin
                    state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase
    end

    always_ff @(posedge eth_clk_i or posedge eth_rst_i) begin
        if (eth_rst_i) begin
            hdr           <= 48'h0;
            hdr_cnt       <= 3'd0;
            rd_idx        <= 3'd0;
            byte_cnt      <= 11'd0;
            drop_event_o  <= 1'b0;
            trunc_event_o <= 1'b0;
            err_event_o   <= 1'b0;
        end else begin
            drop_event_o  <= drop_set;
            trunc_event_o <= trunc_set;
            err_event_o   <= err_set;
            case (state)
                HDR: begin
                    rd_idx <= 3'd0;
                    if (s_axis_tvalid_i) begin
                        hdr <= dst_next;
                        if (s_axis_tlast_i || hdr_cnt == 3'd5) begin
                            hdr_cnt <= 3'd0;
                        end else begin
                            hdr_cnt <= hdr_cnt + 3'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (m_axis_tready_i) begin
                        if (rd_idx == 3'd5) begin
                            rd_idx   <= 3'd0;
                            byte_cnt <= 11'd6;
                        end else begin
                            rd_idx <= rd_idx + 3'd1;
                        end
                    end
                end
                PASS: begin
                    if (in_beat) begin
                        byte_cnt <= byte_cnt_inc;
                    end
                end
                DROP: begin
                    hdr_cnt <= 3'd0;
                end
                default: begin
                    hdr_cnt <= 3'd0;
                end
            endcase
        end
    end

`ifdef ETH_RX_FILTER_STATS_EN
    logic [15:0] stat_cnt;

    // Drop and truncation pulses are mutually exclusive, so one increment suffices.
    always_ff @(posedge eth_clk_i or posedge eth_rst_i) begin
        if (eth_rst_i) begin
            stat_cnt <= 16'h0000;
        end else if ((drop_event_o || trunc_event_o) && stat_cnt != 16'hFFFF) begin
            stat_cnt <= stat_cnt + 16'd1;
        end
    end

    assign stat_drop_cnt_o = stat_cnt;
`else
    assign stat_drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_udma_eth_rx_frame_filter.sv
// tb/tb_udma_eth_rx_frame_filter.sv - directed self-checking bench for udma_eth_rx_frame_filter
module tb_udma_eth_rx_frame_filter;

`ifdef ETH_RX_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] cfg_mac = 48'h02_00_00_00_00_01;
    logic        cfg_promisc = 1'b0;
    logic        cfg_bcast = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_user = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        drop_ev;
    logic        trunc_ev;
    logic        err_ev;
    logic [15:0] stat_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx [0:255];
    logic [7:0] out_data [0:1023];
    logic       out_last [0:1023];
    int out_total = 0;
    int frame_out_cnt = 0;
    int flush_viol = 0;
    int drop_n = 0;
    int trunc_n = 0;
    int err_n = 0;
    int timeouts = 0;

    udma_eth_rx_frame_filter #(.MAX_FRAME_LEN(100)) dut (
        .eth_clk_i       (clk),
        .eth_rst_i       (rst),
        .cfg_mac_addr_i  (cfg_mac),
        .cfg_promisc_i   (cfg_promisc),
        .cfg_bcast_en_i  (cfg_bcast),
        .s_axis_tdata_i  (s_data),
        .s_axis_tvalid_i (s_valid),
        .s_axis_tlast_i  (s_last),
        .s_axis_tuser_i  (s_user),
        .s_axis_tready_o (s_ready),
        .m_axis_tdata_o  (m_data),
        .m_axis_tvalid_o (m_valid),
        .m_axis_tlast_o  (m_last),
        .m_axis_tready_i (m_ready),
        .drop_event_o    (drop_ev),
        .trunc_event_o   (trunc_ev),
        .err_event_o     (err_ev),
        .stat_drop_cnt_o (stat_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge view is exactly what the next edge consumes.
    always @(negedge clk) begin
        if (rst) begin
            frame_out_cnt = 0;
        end else begin
            if (m_valid && frame_out_cnt < 6 && s_ready) flush_viol++;
            if (m_valid && m_ready) begin
                if (out_total < 1024) begin
                    out_data[out_total] = m_data;
                    out_last[out_total] = m_last;
                end
                out_total++;
                frame_out_cnt = m_last ? 0 : frame_out_cnt + 1;
            end
            if (drop_ev)  drop_n++;
            if (trunc_ev) trunc_n++;
            if (err_ev)   err_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [47:0] dst, input int len);
        for (int i = 0; i < 256; i++) begin
            if (i < 6) tx[i] = dst[47-8*i -: 8];
            else       tx[i] = 8'(i * 7 + 3);
        end
        if (len < 0) timeouts++;
    endtask

    task automatic send(input int n, input int cnt, input bit tuser, input bit toggle);
        logic acc;
        for (int i = 0; i < cnt; i++) begin
            s_data  = tx[i];
            s_valid = 1'b1;
            s_last  = (i == n - 1);
            s_user  = tuser && (i == n - 1);
            acc     = 1'b0;
            for (int w = 0; w < 200 && !acc; w++) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                if (toggle) m_ready = ~m_ready;
            end
            if (!acc) timeouts++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_user  = 1'b0;
        m_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int start, input int exp_len);
        int n;
        int bad;
        n   = out_total - start;
        bad = 0;
        chk({tag, "_len"}, n, exp_len);
        for (int i = 0; i < n && i < exp_len; i++) begin
            if (out_data[start + i] !== tx[i]) bad++;
            if (out_last[start + i] !== (i == exp_len - 1)) bad++;
        end
        chk({tag, "_data"}, bad, 0);
    endtask

    initial begin
        int st;
        int d0;
        int t0;
        int e0;
        int v0;

        #12;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_events", {drop_ev, trunc_ev, err_ev}, 0);
        chk("rst_cnt", stat_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 64-byte matching frame, downstream always ready
        build_frame(48'h02_00_00_00_00_01, 64);
        st = out_total; d0 = drop_n; t0 = trunc_n; e0 = err_n;
        send(64, 64, 1'b0, 1'b0);
        check_out("match64", st, 64);
        chk("match64_events", (drop_n - d0) + (trunc_n - t0) + (err_n - e0), 0);

        // same frame with downstream ready toggling
        st = out_total; v0 = flush_viol;
        send(64, 64, 1'b0, 1'b1);
        check_out("toggle64", st, 64);
        chk("toggle64_flush_ready", flush_viol - v0, 0);

        // address miss, broadcast disabled, broadcast enabled
        d0 = drop_n; st = out_total;
        build_frame(48'h02_00_00_00_00_02, 20);
        send(20, 20, 1'b0, 1'b0);
        build_frame(48'hFF_FF_FF_FF_FF_FF, 20);
        send(20, 20, 1'b0, 1'b0);
        chk("miss_out", out_total - st, 0);
        chk("miss_drops", drop_n - d0, 2);
        chk("miss_cnt", stat_cnt, STATS ? 2 : 0);
        cfg_bcast = 1'b1;
        st = out_total;
        send(20, 20, 1'b0, 1'b0);
        check_out("bcast", st, 20);
        cfg_bcast = 1'b0;

        // 4-byte and 6-byte runts, then a minimal 7-byte frame
        d0 = drop_n; st = out_total;
        build_frame(48'h02_00_00_00_00_01, 4);
        send(4, 4, 1'b0, 1'b0);
        send(6, 6, 1'b0, 1'b0);
        chk("runt_out", out_total - st, 0);
        chk("runt_drops", drop_n - d0, 2);
        chk("runt_cnt", stat_cnt, STATS ? 4 : 0);
        send(7, 7, 1'b0, 1'b0);
        check_out("min7", st, 7);

        // 150-byte frame truncated at 100, then a normal frame
        d0 = drop_n; t0 = trunc_n; st = out_total;
        build_frame(48'h02_00_00_00_00_01, 150);
        send(150, 150, 1'b0, 1'b0);
        check_out("trunc", st, 100);
        chk("trunc_pulses", trunc_n - t0, 1);
        chk("trunc_no_drop", drop_n - d0, 0);
        chk("trunc_cnt", stat_cnt, STATS ? 5 : 0);
        st = out_total;
        send(12, 12, 1'b0, 1'b0);
        check_out("post_trunc", st, 12);

        // exactly MAX_FRAME_LEN bytes ends normally
        t0 = trunc_n; st = out_total;
        send(100, 100, 1'b0, 1'b0);
        check_out("exact100", st, 100);
        chk("exact100_no_trunc", trunc_n - t0, 0);

        // MAC error flag on tlast
        e0 = err_n; st = out_total;
        send(30, 30, 1'b1, 1'b0);
        check_out("tuser", st, 30);
        chk("tuser_err", err_n - e0, 1);

        // promiscuous accepts a foreign address
        cfg_promisc = 1'b1;
        st = out_total;
        build_frame(48'h0A_0B_0C_0D_0E_0F, 9);
        send(9, 9, 1'b0, 1'b0);
        check_out("promisc", st, 9);
        cfg_promisc = 1'b0;

        // asynchronous reset in the middle of a forwarded frame
        build_frame(48'h02_00_00_00_00_01, 40);
        send(40, 20, 1'b0, 1'b0);
        s_data  = tx[20];
        s_valid = 1'b1;
        #1;
        chk("mid_pass_valid", m_valid, 1);
        chk("mid_pass_data", m_data, {24'h0, tx[20]});
        rst = 1'b1;
        #1;
        chk("arst_s_ready", s_ready, 1);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_last", m_last, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_events", {drop_ev, trunc_ev, err_ev}, 0);
        chk("arst_cnt", stat_cnt, 0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("accept_timeouts", timeouts, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
